// File: rtl/quad_pkg.sv
// Shared types and phase helpers for the quadrature decoder.
package quad_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      TRACK = 1'b1
   } state_t;

   // Gray-code phases as {A,B}
   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_01 = 2'b01;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_10 = 2'b10;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Run/stability counters are sized for the largest legal FILTER_LEN (255)
   localparam int unsigned FILT_CNT_W = 8;

   // Successor phase in the up sequence 00->01->11->10->00
   function automatic logic [1:0] next_up(input logic [1:0] phase);
      logic [1:0] nxt;
      nxt = PH_00;
      case (phase)
         PH_00:   nxt = PH_01;
         PH_01:   nxt = PH_11;
         PH_11:   nxt = PH_10;
         default: nxt = PH_00;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/glitch_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one encoder channel.
// Also reports when the synchronised level has held steady for FILTER_LEN edges.
module glitch_filter
   import quad_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   input  logic load,
   output logic sync_lvl,
   output logic filt,
   output logic stable_c
);

   localparam logic [FILT_CNT_W-1:0] LEN    = FILT_CNT_W'(FILTER_LEN);
   localparam logic [FILT_CNT_W-1:0] LEN_M1 = FILT_CNT_W'(FILTER_LEN - 1);
   localparam logic [FILT_CNT_W-1:0] ONE    = FILT_CNT_W'(1);

   logic                  sync1;
   logic [FILT_CNT_W-1:0] run_cnt;
   logic [FILT_CNT_W-1:0] stab_cnt;

   // Metastability guard; only the second stage is used downstream
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1    <= 1'b0;
         sync_lvl <= 1'b0;
      end else begin
         sync1    <= raw;
         sync_lvl <= sync1;
      end
   end

   // Filtered level only follows a run of FILTER_LEN consecutive differing samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt    <= 1'b0;
         run_cnt <= '0;
      end else if (load) begin
         filt    <= sync_lvl;
         run_cnt <= '0;
      end else if (sync_lvl != filt) begin
         if (run_cnt == LEN_M1) begin
            filt    <= sync_lvl;
            run_cnt <= '0;
         end else begin
            run_cnt <= run_cnt + ONE;
         end
      end else begin
         run_cnt <= '0;
      end
   end

   // sync1 is the next sync_lvl, so equality means the level holds across this edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stab_cnt <= '0;
      end else if (sync1 != sync_lvl) begin
         stab_cnt <= '0;
      end else if (stab_cnt != LEN) begin
         stab_cnt <= stab_cnt + ONE;
      end
   end

   assign stable_c = (stab_cnt == LEN);

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: filtered Gray-phase tracking producing a step qualifier,
// direction level and a sticky/saturating illegal-transition report.
module quadrature_decoder
   import quad_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 3,
   parameter int unsigned ERR_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_in,
   input  logic             b_in,
   input  logic             clr_err,
   output logic             step,
   output logic             up_down,
   output logic             err,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [ERR_W-1:0] ERR_MAX = '1;
   localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

   logic       a_sync, b_sync;
   logic       a_filt, b_filt;
   logic       a_stable_c, b_stable_c;
   logic       load_c;
   logic [1:0] cur_c;
   logic [1:0] prev;
   logic       is_up_c, is_dn_c, is_ill_c;
   state_t     state;

   glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
      .clk      (clk),
      .rst      (rst),
      .raw      (a_in),
      .load     (load_c),
      .sync_lvl (a_sync),
      .filt     (a_filt),
      .stable_c (a_stable_c)
   );

   glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
      .clk      (clk),
      .rst      (rst),
      .raw      (b_in),
      .load     (load_c),
      .sync_lvl (b_sync),
      .filt     (b_filt),
      .stable_c (b_stable_c)
   );

   // INIT absorbs the power-up phase once both channels have settled
   assign load_c = (state == INIT) && a_stable_c && b_stable_c;
   assign cur_c  = {a_filt, b_filt};

   always_comb begin
      is_up_c  = (next_up(prev) == cur_c);
      is_dn_c  = (next_up(cur_c) == prev);
      is_ill_c = (cur_c != prev) && !is_up_c && !is_dn_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INIT;
         prev      <= PH_00;
         step      <= 1'b0;
         up_down   <= DIR_DOWN;
         err       <= 1'b0;
         err_count <= '0;
      end else begin
         step <= 1'b0;

         case (state)
            INIT: begin
               if (load_c) begin
                  prev  <= {a_sync, b_sync};
                  state <= TRACK;
               end
            end
            TRACK: begin
               prev <= cur_c;
               if (is_up_c) begin
                  step    <= 1'b1;
                  up_down <= DIR_UP;
               end else if (is_dn_c) begin
                  step    <= 1'b1;
                  up_down <= DIR_DOWN;
               end
            end
         endcase

         // A fresh illegal transition beats a simultaneous clear
         if ((state == TRACK) && is_ill_c) begin
            err <= 1'b1;
            if (clr_err)
               err_count <= ERR_ONE;
            else if (err_count != ERR_MAX)
               err_count <= err_count + ERR_ONE;
         end else if (clr_err) begin
            err       <= 1'b0;
            err_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Randomised scoreboard bench for quadrature_decoder against a history-based reference model.
module tb_quadrature_decoder;

   localparam int unsigned FL    = 3;
   localparam int unsigned ERR_W = 8;
   localparam int          ERR_SAT = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             a_in = 1'b0;
   logic             b_in = 1'b0;
   logic             clr_err = 1'b0;
   logic             step;
   logic             up_down;
   logic             err;
   logic [ERR_W-1:0] err_count;

   typedef struct packed {
      logic             step;
      logic             up_down;
      logic             err;
      logic [ERR_W-1:0] cnt;
   } obs_t;

   obs_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   quadrature_decoder #(.FILTER_LEN(FL), .ERR_W(ERR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_in      (a_in),
      .b_in      (b_in),
      .clr_err   (clr_err),
      .step      (step),
      .up_down   (up_down),
      .err       (err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Position of a phase on the up circle; the step is the difference mod 4.
   function automatic int gpos(input logic [1:0] p);
      case (p)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   logic [1:0] rawq[$];   // raw {A,B} seen at each edge since reset
   logic [1:0] shq[$];    // synchronised {A,B} presented to the logic at each edge
   int         m_n;
   bit         m_trk;
   logic [1:0] m_prev;
   logic [1:0] m_f;
   int         m_clr[2];
   obs_t       m_out;

   task automatic m_reset();
      rawq.delete();
      shq.delete();
      m_n = 0; m_trk = 0; m_prev = 2'b00; m_f = 2'b00;
      m_clr[0] = 0; m_clr[1] = 0;
      m_out = '0;
   endtask

   function automatic bit window_const(input int len);
      for (int i = shq.size() - len; i < shq.size(); i++)
         if (shq[i] != shq[shq.size()-1]) return 1'b0;
      return 1'b1;
   endfunction

   // A channel flips once the last FL samples since its last settle all disagree with it
   task automatic m_filter();
      for (int c = 0; c < 2; c++) begin
         bit hit;
         hit = 1'b0;
         if (m_n - m_clr[c] >= int'(FL)) begin
            hit = 1'b1;
            for (int i = shq.size() - int'(FL); i < shq.size(); i++)
               if (shq[i][c] == m_f[c]) hit = 1'b0;
         end
         if (hit) begin
            m_f[c]   = ~m_f[c];
            m_clr[c] = m_n;
         end
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk);
         if (rst) begin
            m_reset();
         end else begin
            logic [1:0] s2;
            int         d;
            bit         ill;
            int         c;
            m_n++;
            s2 = (m_n >= 3) ? rawq[m_n-3] : 2'b00;
            shq.push_back(s2);
            rawq.push_back({a_in, b_in});
            m_out.step = 1'b0;
            ill = 1'b0;
            if (!m_trk) begin
               if (m_n >= int'(FL) + 1 && window_const(int'(FL) + 1)) begin
                  m_trk = 1'b1; m_f = s2; m_prev = s2;
                  m_clr[0] = m_n; m_clr[1] = m_n;
               end else begin
                  m_filter();
               end
            end else begin
               d = (gpos(m_f) - gpos(m_prev) + 4) % 4;
               if (d == 1) begin
                  m_out.step = 1'b1; m_out.up_down = 1'b1;
               end else if (d == 3) begin
                  m_out.step = 1'b1; m_out.up_down = 1'b0;
               end else if (d == 2) begin
                  ill = 1'b1;
               end
               m_prev = m_f;
               m_filter();
            end
            if (ill) begin
               c = int'(m_out.cnt);
               m_out.err = 1'b1;
               m_out.cnt = clr_err ? ERR_W'(1) : ERR_W'((c + 1 > ERR_SAT) ? ERR_SAT : c + 1);
            end else if (clr_err) begin
               m_out.err = 1'b0;
               m_out.cnt = '0;
            end
         end
         exp_q.push_back(m_out);
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         obs_t e;
         obs_t g;
         @(negedge clk);
         if (exp_q.size() == 0) begin
            if (!rst) begin
               n_tests++; n_fail++;
               $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
            end
         end else begin
            e = exp_q.pop_front();
            g = {step, up_down, err, err_count};
            if (!rst) begin
               n_tests++;
               if (g !== e) begin
                  n_fail++;
                  $display("FAIL outputs at %0t: got step=%b up_down=%b err=%b err_count=%0d, expected step=%b up_down=%b err=%b err_count=%0d",
                           $time, g.step, g.up_down, g.err, g.cnt, e.step, e.up_down, e.err, e.cnt);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic set_ab(input logic [1:0] v);
      @(posedge clk);
      #1 {a_in, b_in} = v;
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic count_steps(input int cycles, output int cnt);
      cnt = 0;
      repeat (cycles) begin
         @(posedge clk);
         #1 if (step) cnt++;
      end
   endtask

   // Drive one phase change and measure edges until the step shows
   task automatic drive_step(input logic [1:0] v, input logic dir, input string name);
      int k;
      set_ab(v);
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (step) begin
            k = i;
            break;
         end
      end
      check({name, "_latency"}, k, int'(FL) + 3);
      check({name, "_dir"}, int'(up_down), int'(dir));
      if (k > 0 && k < 10) hold(10 - k);
   endtask

   initial begin
      int cnt;
      // reset state
      #1;
      check("reset_step", int'(step), 0);
      check("reset_up_down", int'(up_down), 0);
      check("reset_err", int'(err), 0);
      check("reset_err_count", int'(err_count), 0);

      // hold 11 through reset release: INIT absorbs it silently
      {a_in, b_in} = 2'b11;
      hold(2);
      #1 rst = 1'b0;
      count_steps(10, cnt);
      check("init_no_step", cnt, 0);
      check("init_err", int'(err), 0);
      check("init_track", int'(dut.state == quad_pkg::TRACK), 1);

      // reach 00 legally, then the full up cycle
      drive_step(2'b10, 1'b1, "to10");
      drive_step(2'b00, 1'b1, "to00");
      drive_step(2'b01, 1'b1, "up01");
      drive_step(2'b11, 1'b1, "up11");
      drive_step(2'b10, 1'b1, "up10");
      drive_step(2'b00, 1'b1, "up00");
      check("up_err_count", int'(err_count), 0);

      // down cycle then reversal
      drive_step(2'b10, 1'b0, "dn10");
      drive_step(2'b11, 1'b0, "dn11");
      drive_step(2'b01, 1'b0, "dn01");
      drive_step(2'b00, 1'b0, "dn00");
      drive_step(2'b01, 1'b1, "rev01");

      // glitches on A from 01
      set_ab(2'b11);
      hold(2);
      #1 a_in = 1'b0;
      count_steps(15, cnt);
      check("glitch2_steps", cnt, 0);
      check("glitch2_filt_a", int'(dut.u_filt_a.filt), 0);
      set_ab(2'b11);
      hold(3);
      #1 a_in = 1'b0;
      count_steps(20, cnt);
      check("pulse3_steps", cnt, 2);
      check("pulse3_dir", int'(up_down), 0);

      // illegal transitions and saturation
      drive_step(2'b00, 1'b0, "back00");
      set_ab(2'b11);
      count_steps(10, cnt);
      check("ill_no_step", cnt, 0);
      check("ill_err", int'(err), 1);
      check("ill_err_count", int'(err_count), 1);
      for (int i = 1; i < 300; i++) begin
         set_ab((i % 2 == 1) ? 2'b00 : 2'b11);
         hold(6);
      end
      hold(2);
      #1 check("sat_err_count", int'(err_count), ERR_SAT);

      // clear coincident with a new illegal transition
      set_ab(2'b11);
      hold(5);
      #1 clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
      check("clr_race_err", int'(err), 1);
      check("clr_race_count", int'(err_count), 1);
      hold(3);
      #1 clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
      check("clr_err", int'(err), 0);
      check("clr_count", int'(err_count), 0);

      // mid-operation reset with the filter mid-run
      set_ab(2'b00);
      hold(10);
      drive_step(2'b01, 1'b1, "pre_rst01");
      check("pre_rst_err", int'(err), 1);
      set_ab(2'b11);
      hold(3);
      #2 rst = 1'b1;
      #1;
      check("midrst_step", int'(step), 0);
      check("midrst_up_down", int'(up_down), 0);
      check("midrst_err", int'(err), 0);
      check("midrst_count", int'(err_count), 0);
      {a_in, b_in} = 2'b10;
      hold(2);
      #1 rst = 1'b0;
      count_steps(20, cnt);
      check("post_rst_steps", cnt, 0);
      check("post_rst_err", int'(err), 0);

      // randomised segments, checked by the scoreboard
      for (int s = 0; s < 1500; s++) begin
         int h;
         logic [1:0] v;
         v = 2'($urandom_range(0, 3));
         h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, FL - 1)) : int'($urandom_range(FL, 12));
         @(posedge clk);
         #1 {a_in, b_in} = v;
         clr_err = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 199) == 0) rst = 1'b1;
         @(posedge clk);
         #1 clr_err = 1'b0;
         rst = 1'b0;
         if (h > 1) hold(h - 1);
      end
      hold(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
- Front-end stage for the up/down counter. It decodes a two-channel quadrature encoder (A/B) into a one-cycle step qualifier and a direction level (1 = up, 0 = down).
- It synchronises and glitch-filters the raw pins, tracks the Gray-code phase, and flags illegal (double-bit) transitions.
- up_down drives the counter's direction input directly; step is the count qualifier.

Parameters:
- FILTER_LEN, default 3: consecutive identical synchronised samples needed before a channel's filtered level changes. Legal range 1..255.
- ERR_W, default 8: width of the saturating illegal-transition counter.

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- a_in  in  1  raw encoder channel A, asynchronous to clk
- b_in  in  1  raw encoder channel B, asynchronous to clk
- clr_err  in  1  synchronous clear of err and err_count
- step  out  1  one-cycle pulse per legal quarter-step
- up_down  out  1  direction of the last legal step (1 = up, 0 = down)
- err  out  1  sticky illegal-transition flag
- err_count  out  ERR_W  saturating count of illegal transitions

Behaviour:
- Reset (async, active-high):
  - sync flops, filter counters, filtered A/B and prev phase all cleared to 0.
  - step=0, up_down=0, err=0, err_count=0.
  - FSM enters INIT.
- Synchroniser: a two-flop chain per channel. Only the sync2 outputs are used downstream.
- Filter (per channel):
  - Tracks a candidate level against the current filtered level.
  - Each cycle that sync2 differs from filtered, the run counter increments; a sample equal to filtered resets it to 0.
  - When the counter reaches FILTER_LEN, filtered takes the sync2 value and the counter clears.
  - Pulses shorter than FILTER_LEN cycles are invisible.
- FSM state INIT:
  - Waits until both channels' sync2 values have been stable for FILTER_LEN cycles.
  - Then loads filtered A/B and prev phase with {A,B} and goes to TRACK.
  - No step or err is produced in INIT, so the power-up phase is never a transition.
- FSM state TRACK: each cycle, compare cur={A_f,B_f} against prev.
  - Equal: step=0, up_down holds.
  - Up sequence 00->01->11->10->00: step=1 next cycle, up_down=1.
  - Reverse sequence 00->10->11->01->00: step=1, up_down=0.
  - Both bits changed (00<->11, 01<->10): step=0, up_down holds, err=1, err_count+1 saturating at 2^ERR_W-1.
  - prev<=cur on every cycle.
- Latency:
  - Raw edge sampled at edge E0. sync2 at E1, filtered at E(1+FILTER_LEN), step high after E(2+FILTER_LEN).
  - For FILTER_LEN=3, step is high for the cycle after edge 5.
  - step is registered and never high two consecutive cycles for a single transition.
- clr_err:
  - Clears err and err_count next edge.
  - If an illegal transition is detected in the same cycle, the error wins: err=1, err_count=1.
- Mid-operation reset: immediately returns all state and outputs to reset values and re-enters INIT. No spurious step on release.
- Direction reversal between adjacent steps is legal: e.g. 01->11 then 11->01 gives two steps, up_down 1 then 0.

Decomposition:
- Package quad_pkg holds:
  - state enum {INIT, TRACK}
  - 2-bit phase constants PH_00, PH_01, PH_11, PH_10
  - DIR_UP=1, DIR_DOWN=0
  - a function next_up(phase) returning the successor phase in the up sequence.
- Sub-module glitch_filter (parameter FILTER_LEN): synchroniser plus run-length filter for one channel, instantiated twice. It also exports a stable flag used by INIT.

Test Plan:
1. Reset then hold A=1,B=1 for 10 cycles -> FSM reaches TRACK; step never pulses; err=0.
2. FILTER_LEN=3, from 00 drive 01,11,10,00 with each level held 10 cycles -> 4 step pulses, each 6 edges after its input change; up_down=1; err_count=0.
3. From 00 drive 10,11,01,00 -> 4 pulses, up_down=0. Then 01 -> one pulse and up_down=1 (reversal).
4. A pulses high for 2 cycles (FILTER_LEN=3) -> no step, filtered A unchanged. A 3-cycle pulse -> step up, then step down on return.
5. From 00 change A and B together to 11 -> err=1, err_count=1, no step. Repeat 300 times with ERR_W=8 -> err_count saturates at 255. Assert clr_err coincident with a new illegal transition -> err=1, err_count=1.
6. Assert rst mid-sequence while filter counters are non-zero -> all outputs 0 within the same cycle. After release with input 10, INIT absorbs the phase and no step or err occurs.
